// File: rtl/vga_layer_mixer.sv
// N-layer priority compositor: background plus LAYERS sprite layers, with blanking and timing delay.
// Defining VGA_MIXER_FADE_EN adds a frame-synchronous fade-to-black/fade-in stage (latency 3 instead of 2).
module vga_layer_mixer #(
  parameter int LAYERS     = 4,
  parameter int CW         = 4,
  parameter int TW         = 11,
  parameter int FADE_STEPS = 16,
  parameter int FADE_DIV   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TW-1:0]              hcount_in,
  input  logic [TW-1:0]              vcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       hblnk_in,
  input  logic                       vblnk_in,
  input  logic [3*CW-1:0]            bg_rgb,
  input  logic [LAYERS*3*CW-1:0]     layer_rgb,
  input  logic [LAYERS-1:0]          layer_opq,
  input  logic [LAYERS-1:0]          layer_mask,
  input  logic                       fade_req,
  output logic [TW-1:0]              hcount_out,
  output logic [TW-1:0]              vcount_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       hblnk_out,
  output logic                       vblnk_out,
  output logic [3*CW-1:0]            rgb_out,
  output logic [$clog2(LAYERS+1)-1:0] hit_layer,
  output logic                       fade_busy,
  output logic                       fade_black
);

  localparam int PW  = 3 * CW;
  localparam int HW  = $clog2(LAYERS + 1);
  localparam int TBW = 2 * TW + 4;

  logic                vsync_prev;
  logic                frame_tick;
  logic [LAYERS-1:0]   mask;
  logic [TBW-1:0]      tim_in;

  assign frame_tick = vsync_in & ~vsync_prev;
  assign tim_in     = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

  // Mask only changes on a frame tick so a layer never disappears mid-frame.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_prev <= 1'b0;
      mask       <= '0;
    end else begin
      vsync_prev <= vsync_in;
      if (frame_tick) mask <= layer_mask;
    end
  end

  logic [PW-1:0] sel_rgb;
  logic [HW-1:0] sel_hit;

  // Ascending scan: the last opaque, enabled layer (highest index) wins.
  // NOTE: defaults first in combinational blocks so no path leaves a latch behind.
  always_comb begin
    sel_rgb = bg_rgb;
    sel_hit = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (layer_opq[i] && mask[i]) begin
        sel_rgb = layer_rgb[i*PW +: PW];
        sel_hit = HW'(i + 1);
      end
    end
  end

  logic [PW-1:0]  s1_rgb;
  logic [HW-1:0]  s1_hit;
  logic [TBW-1:0] s1_tim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_rgb <= '0;
      s1_hit <= '0;
      s1_tim <= '0;
    end else begin
      s1_rgb <= sel_rgb;
      s1_hit <= sel_hit;
      s1_tim <= tim_in;
    end
  end

  logic [PW-1:0]  pre_rgb;
  logic [HW-1:0]  pre_hit;
  logic [TBW-1:0] pre_tim;

`ifdef VGA_MIXER_FADE_EN
  localparam int FS_LOG = $clog2(FADE_STEPS);
  localparam int LW     = FS_LOG + 1;
  localparam int DW     = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FADE_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FADE_STEPS);

  typedef enum logic [1:0] {IDLE, FADE_OUT, HOLD, FADE_IN} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] level, level_nxt;
  logic [DW-1:0] div, div_nxt;
  logic          black_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      level      <= LVL_FULL;
      div        <= '0;
      fade_black <= 1'b0;
    end else begin
      state      <= state_nxt;
      level      <= level_nxt;
      div        <= div_nxt;
      fade_black <= black_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    div_nxt   = div;
    black_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        level_nxt = LVL_FULL;
        if (fade_req) state_nxt = FADE_OUT;
      end
      FADE_OUT: if (frame_tick) begin
        if (div == DIV_LAST) begin
          div_nxt = '0;
          if (level != '0) level_nxt = level - LW'(1);
          if (level <= LW'(1)) begin
            state_nxt = HOLD;
            black_nxt = 1'b1;
          end
        end else div_nxt = div + DW'(1);
      end
      HOLD: if (frame_tick) begin
        if (div == DIV_LAST) state_nxt = FADE_IN;
        else div_nxt = div + DW'(1);
      end
      FADE_IN: if (frame_tick) begin
        if (div == DIV_LAST) begin
          div_nxt = '0;
          if (level != LVL_FULL) level_nxt = level + LW'(1);
          if (level >= LW'(FADE_STEPS - 1)) state_nxt = IDLE;
        end else div_nxt = div + DW'(1);
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) div_nxt = '0;
  end

  assign fade_busy = (state != IDLE);

  function automatic logic [PW-1:0] scale(input logic [PW-1:0] px, input logic [LW-1:0] lv);
    logic [PW-1:0]    res;
    logic [CW+LW-1:0] prod;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      prod = (CW+LW)'(px[c*CW +: CW]) * (CW+LW)'(lv);
      res[c*CW +: CW] = CW'(prod >> FS_LOG);
    end
    return res;
  endfunction

  logic [PW-1:0]  s2_rgb;
  logic [HW-1:0]  s2_hit;
  logic [TBW-1:0] s2_tim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_rgb <= '0;
      s2_hit <= '0;
      s2_tim <= '0;
    end else begin
      s2_rgb <= scale(s1_rgb, level);
      s2_hit <= s1_hit;
      s2_tim <= s1_tim;
    end
  end

  assign pre_rgb = s2_rgb;
  assign pre_hit = s2_hit;
  assign pre_tim = s2_tim;
`else
  logic unused_fade_req;
  assign unused_fade_req = fade_req;
  assign fade_busy  = 1'b0;
  assign fade_black = 1'b0;
  assign pre_rgb    = s1_rgb;
  assign pre_hit    = s1_hit;
  assign pre_tim    = s1_tim;
`endif

  // Blanking uses the delayed flags; hit_layer still reports the winner during blanking.
  // NOTE: only pipeline/control registers exist here, so every one of them is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out    <= '0;
      hit_layer  <= '0;
      {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} <= '0;
    end else begin
      rgb_out    <= (pre_tim[1] | pre_tim[0]) ? '0 : pre_rgb;
      hit_layer  <= pre_hit;
      {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} <= pre_tim;
    end
  end

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Self-checking bench for vga_layer_mixer: table-driven priority/mask/blank vectors via a scoreboard,
// plus hand-written frame sequences for the fade (or its absence when VGA_MIXER_FADE_EN is undefined).
`timescale 1ns/1ps
module tb_vga_layer_mixer;

  localparam int LAYERS = 4;
  localparam int CW     = 4;
  localparam int TW     = 11;
  localparam int PW     = 3 * CW;
  localparam int HW     = 3;
  localparam int TBW    = 2 * TW + 4;
`ifdef VGA_MIXER_FADE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                   clk, rst;
  logic [TW-1:0]          hcount_in, vcount_in, hcount_out, vcount_out;
  logic                   hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic                   hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [PW-1:0]          bg_rgb, rgb_out;
  logic [LAYERS*PW-1:0]   layer_rgb;
  logic [LAYERS-1:0]      layer_opq, layer_mask;
  logic                   fade_req, fade_busy, fade_black;
  logic [HW-1:0]          hit_layer;

  vga_layer_mixer dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .bg_rgb(bg_rgb), .layer_rgb(layer_rgb), .layer_opq(layer_opq), .layer_mask(layer_mask),
    .fade_req(fade_req),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .hit_layer(hit_layer), .fade_busy(fade_busy), .fade_black(fade_black)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0]     bg;
    logic [LAYERS-1:0] opq;
    logic [LAYERS-1:0] mask;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
    logic [PW-1:0]     exp_rgb;
    logic [HW-1:0]     exp_hit;
  } vec_t;

  typedef struct packed {
    logic [31:0]    due;
    logic [PW-1:0]  rgb;
    logic [HW-1:0]  hit;
    logic [TBW-1:0] tim;
  } sb_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];
  sb_t  sb [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ticks = 0;
  int black_cnt = 0;
  int black_tick = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample 1 ns after the edge, retire any scoreboard entries due now.
  task automatic step();
    sb_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (fade_black === 1'b1) begin
      black_cnt++;
      black_tick = ticks;
    end
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("sb_rgb", 64'(rgb_out), 64'(e.rgb));
      check("sb_hit", 64'(hit_layer), 64'(e.hit));
      check("sb_timing", 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
            64'(e.tim));
    end
  endtask

  task automatic drive_vec(input int i);
    sb_t e;
    hcount_in  = TW'(i * 7 + 3);
    vcount_in  = TW'(i);
    hsync_in   = (i % 3 == 0);
    vsync_in   = vecs[i].vsync;
    hblnk_in   = vecs[i].hblnk;
    vblnk_in   = vecs[i].vblnk;
    bg_rgb     = vecs[i].bg;
    layer_opq  = vecs[i].opq;
    layer_mask = vecs[i].mask;
    e.due = 32'(cyc + LAT);
    e.rgb = vecs[i].exp_rgb;
    e.hit = vecs[i].exp_hit;
    e.tim = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
    sb.push_back(e);
  endtask

  // A frame is one vsync-high cycle (the tick) followed by five low cycles.
  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      vsync_in = 1'b1;
      ticks++;
      step();
      vsync_in = 1'b0;
      repeat (5) step();
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Layer colours: l3=FFF, l2=0F0, l1=FF0, l0=F00
    vecs[0]  = '{12'h00F, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 12'h00F, 3'd0};
    vecs[1]  = '{12'h00F, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 12'h00F, 3'd0};
    vecs[2]  = '{12'h00F, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0, 12'h0F0, 3'd3};
    vecs[3]  = '{12'h00F, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0, 12'hF00, 3'd1};
    vecs[4]  = '{12'h123, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 12'h123, 3'd0};
    vecs[5]  = '{12'h123, 4'hA, 4'hF, 1'b0, 1'b0, 1'b0, 12'hFFF, 3'd4};
    vecs[6]  = '{12'h123, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0, 12'hFF0, 3'd2};
    vecs[7]  = '{12'h123, 4'h8, 4'hF, 1'b0, 1'b1, 1'b0, 12'h000, 3'd4};
    vecs[8]  = '{12'h123, 4'h4, 4'hF, 1'b0, 1'b0, 1'b1, 12'h000, 3'd3};
    vecs[9]  = '{12'h00F, 4'h5, 4'h0, 1'b0, 1'b0, 1'b0, 12'h0F0, 3'd3};
    vecs[10] = '{12'h00F, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 12'hFFF, 3'd4};
    vecs[11] = '{12'h00F, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 12'hFFF, 3'd4};
    vecs[12] = '{12'h00F, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 12'h00F, 3'd0};
    vecs[13] = '{12'h0AB, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 12'h0AB, 3'd0};
    vecs[14] = '{12'h0AB, 4'h3, 4'h3, 1'b1, 1'b0, 1'b0, 12'h0AB, 3'd0};
    vecs[15] = '{12'h0AB, 4'hF, 4'h3, 1'b0, 1'b0, 1'b0, 12'hFF0, 3'd2};
    vecs[16] = '{12'h555, 4'hC, 4'h3, 1'b0, 1'b0, 1'b0, 12'h555, 3'd0};
    vecs[17] = '{12'h555, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 12'hFF0, 3'd2};

    rst = 1'b1;
    hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    bg_rgb = 12'hABC; layer_opq = '1; layer_mask = '1; fade_req = 1'b0;
    layer_rgb = {12'hFFF, 12'h0F0, 12'hFF0, 12'hF00};
    repeat (2) step();

    check("reset_rgb", 64'(rgb_out), 64'h0);
    check("reset_hit", 64'(hit_layer), 64'h0);
    check("reset_timing", 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 64'h0);
    check("reset_busy", 64'(fade_busy), 64'h0);
    check("reset_black", 64'(fade_black), 64'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < NVEC; i++) begin
      drive_vec(i);
      step();
    end
    layer_opq = '0;
    repeat (LAT + 1) step();
    check("sb_drain", 64'(sb.size()), 64'h0);

    bg_rgb = 12'hFFF; layer_opq = '0; layer_mask = '1;
    hblnk_in = 1'b0; vblnk_in = 1'b0;
    ticks = 0;
`ifdef VGA_MIXER_FADE_EN
    fade_req = 1'b1; step(); fade_req = 1'b0;
    check("fade_busy_start", 64'(fade_busy), 64'h1);
    frames(1);
    check("fade_tick1_rgb", 64'(rgb_out), 64'hFFF);
    frames(1);
    check("fade_tick2_rgb", 64'(rgb_out), 64'hEEE);
    fade_req = 1'b1; step(); fade_req = 1'b0; step();
    frames(30);
    check("fade_tick32_rgb", 64'(rgb_out), 64'h000);
    check("fade_black_seen", 64'(black_cnt), 64'h1);
    frames(6);
    check("fade_tick38_rgb", 64'(rgb_out), 64'h111);
    frames(27);
    check("fade_tick65_busy", 64'(fade_busy), 64'h1);
    frames(1);
    check("fade_tick66_busy", 64'(fade_busy), 64'h0);
    check("fade_tick66_rgb", 64'(rgb_out), 64'hFFF);
    check("fade_black_count", 64'(black_cnt), 64'h1);
    check("fade_black_tick", 64'(black_tick), 64'd32);

    ticks = 0;
    fade_req = 1'b1; step(); fade_req = 1'b0;
    frames(40);
    check("rst_pre_rgb", 64'(rgb_out), 64'h222);
    #2 rst = 1'b1;
    #1;
    check("rst_async_busy", 64'(fade_busy), 64'h0);
    check("rst_async_rgb", 64'(rgb_out), 64'h0);
    check("rst_async_timing", 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 64'h0);
    check("rst_async_hit", 64'(hit_layer), 64'h0);
    step();
    rst = 1'b0;
    frames(2);
    check("rst_level_full_rgb", 64'(rgb_out), 64'hFFF);
    check("rst_level_busy", 64'(fade_busy), 64'h0);
`else
    fade_req = 1'b1; step(); fade_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      frames(2);
      check("nofade_rgb", 64'(rgb_out), 64'hFFF);
      check("nofade_busy", 64'(fade_busy), 64'h0);
    end
    check("nofade_black", 64'(black_cnt), 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
